// File: rtl/decode_execute_stage.sv
// Decode + execute stage of the single-cycle LEGv8 datapath: control decode, 32x64 register file,
// immediate sign-extension, ALU and branch-target adder. Optional DECODE_BYPASS_EN forwards write_data to reads.
module decode_execute_stage #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instr,
  input  logic [WORD-1:0]      cur_pc,
  input  logic [WORD-1:0]      write_data,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      ext_addr,
  output logic                 uncondbranch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      alu_result,
  output logic                 zero,
  output logic [WORD-1:0]      branch_target
);

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  logic [10:0] opcode;
  logic        is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_b, is_rtype;
  logic [4:0]  rn_addr, r2_addr, wr_addr;
  logic [WORD-1:0] regs [0:31];
  logic [WORD-1:0] rd1_stored, rd2_stored;
  logic [WORD-1:0] alu_b;

  assign opcode   = instr[31:21];
  assign is_add   = (opcode == OP_ADD);
  assign is_sub   = (opcode == OP_SUB);
  assign is_and   = (opcode == OP_AND);
  assign is_orr   = (opcode == OP_ORR);
  assign is_ldur  = (opcode == OP_LDUR);
  assign is_stur  = (opcode == OP_STUR);
  assign is_cbz   = (instr[31:24] == 8'hB4);
  assign is_b     = (instr[31:26] == 6'h05);
  assign is_rtype = is_add | is_sub | is_and | is_orr;

  always_comb begin
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    uncondbranch = 1'b0;
    alu_op       = 2'b00;
    if (is_rtype) begin
      reg_write = 1'b1;
      alu_op    = 2'b10;
    end else if (is_ldur) begin
      alu_src    = 1'b1;
      mem_to_reg = 1'b1;
      reg_write  = 1'b1;
      mem_read   = 1'b1;
    end else if (is_stur) begin
      alu_src   = 1'b1;
      mem_write = 1'b1;
    end else if (is_cbz) begin
      branch = 1'b1;
      alu_op = 2'b01;
    end else if (is_b) begin
      uncondbranch = 1'b1;
    end
  end

  // STUR and CBZ name their second source in the Rt slot rather than Rm.
  assign rn_addr = instr[9:5];
  assign r2_addr = (is_stur | is_cbz) ? instr[4:0] : instr[20:16];
  assign wr_addr = instr[4:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 31; i++) regs[i] <= '0;
    end else if (reg_write && (wr_addr != 5'd31)) begin
      regs[wr_addr] <= write_data;
    end
  end

  assign rd1_stored = (rn_addr == 5'd31) ? '0 : regs[rn_addr];
  assign rd2_stored = (r2_addr == 5'd31) ? '0 : regs[r2_addr];

`ifdef DECODE_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd     = reg_write && reset && (wr_addr != 5'd31);
  assign read_data1 = (wr_fwd && (rn_addr == wr_addr)) ? write_data : rd1_stored;
  assign read_data2 = (wr_fwd && (r2_addr == wr_addr)) ? write_data : rd2_stored;
`else
  assign read_data1 = rd1_stored;
  assign read_data2 = rd2_stored;
`endif

  always_comb begin
    ext_addr = '0;
    if (is_ldur | is_stur) ext_addr = {{(WORD-9){instr[20]}}, instr[20:12]};
    else if (is_cbz)       ext_addr = {{(WORD-19){instr[23]}}, instr[23:5]};
    else if (is_b)         ext_addr = {{(WORD-26){instr[25]}}, instr[25:0]};
  end

  assign alu_b = alu_src ? ext_addr : read_data2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = read_data1 + alu_b;
      2'b01: alu_result = alu_b;
      2'b10: begin
        if (is_sub)      alu_result = read_data1 - alu_b;
        else if (is_and) alu_result = read_data1 & alu_b;
        else if (is_orr) alu_result = read_data1 | alu_b;
        else             alu_result = read_data1 + alu_b;
      end
      default: alu_result = '0;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign branch_target = cur_pc + (ext_addr << 2);

endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: directed checks from the LEGv8 examples plus randomized instructions
// scored against an instruction-level model of the register file and ALU.
module tb_decode_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [63:0] cur_pc, write_data;
  logic [63:0] read_data1, read_data2, ext_addr, alu_result, branch_target;
  logic        uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, zero;
  logic [1:0]  alu_op;

  decode_execute_stage #(.WORD(64), .INSTR_LEN(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .cur_pc(cur_pc), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2), .ext_addr(ext_addr),
    .uncondbranch(uncondbranch), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .alu_result(alu_result), .zero(zero), .branch_target(branch_target)
  );

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mregs [0:31];

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_LDUR, K_STUR, K_CBZ, K_B, K_NOP} kind_t;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic kind_t kind_of(input logic [31:0] ins);
    case (ins[31:21])
      11'h458: return K_ADD;
      11'h658: return K_SUB;
      11'h450: return K_AND;
      11'h550: return K_ORR;
      11'h7C2: return K_LDUR;
      11'h7C0: return K_STUR;
      default: ;
    endcase
    if (ins[31:24] == 8'hB4) return K_CBZ;
    if (ins[31:26] == 6'h05) return K_B;
    return K_NOP;
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    if (v >= (64'd1 << (bits - 1))) return v - (64'd1 << bits);
    return v;
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] a, input logic we, input logic rst,
                                             input logic [4:0] wr, input logic [63:0] wd);
    if (a == 5'd31) return 64'd0;
    if (BYP && we && rst && a == wr) return wd;
    return mregs[a];
  endfunction

  // Expected outputs go to the queue in a fixed order and are popped in the same order.
  task automatic model_step(input logic rst, input logic [31:0] ins, input logic [63:0] pc,
                            input logic [63:0] wd);
    kind_t k;
    logic [4:0] r2, wr;
    logic we;
    logic [63:0] a, b, ext, res;
    logic [8:0] ctrl;
    k  = kind_of(ins);
    r2 = (k == K_STUR || k == K_CBZ) ? ins[4:0] : ins[20:16];
    wr = ins[4:0];
    we = (k == K_ADD || k == K_SUB || k == K_AND || k == K_ORR || k == K_LDUR);
    a  = model_read(ins[9:5], we, rst, wr, wd);
    b  = model_read(r2, we, rst, wr, wd);
    case (k)
      K_LDUR, K_STUR: ext = sext(64'(ins[20:12]), 9);
      K_CBZ:          ext = sext(64'(ins[23:5]), 19);
      K_B:            ext = sext(64'(ins[25:0]), 26);
      default:        ext = 64'd0;
    endcase
    case (k)
      K_SUB:          res = a - b;
      K_AND:          res = a & b;
      K_ORR:          res = a | b;
      K_LDUR, K_STUR: res = a + ext;
      K_CBZ:          res = b;
      default:        res = a + b;
    endcase
    // {uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    case (k)
      K_ADD, K_SUB, K_AND, K_ORR: ctrl = 9'b000000110;
      K_LDUR:  ctrl = 9'b001101100;
      K_STUR:  ctrl = 9'b000011000;
      K_CBZ:   ctrl = 9'b010000001;
      K_B:     ctrl = 9'b100000000;
      default: ctrl = 9'b000000000;
    endcase
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(ext);
    exp_q.push_back(res);
    exp_q.push_back(64'(res == 64'd0));
    exp_q.push_back(pc + ext * 4);
    exp_q.push_back(64'(ctrl));
    if (!rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    end else if (we && wr != 5'd31) begin
      mregs[wr] = wd;
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic rst, input logic [31:0] ins, input logic [63:0] pc,
                       input logic [63:0] wd);
    @(posedge clk);
    #1;
    reset = rst; instr = ins; cur_pc = pc; write_data = wd;
    @(negedge clk);
    model_step(rst, ins, pc, wd);
    check_eq("rd1",  read_data1, exp_q.pop_front());
    check_eq("rd2",  read_data2, exp_q.pop_front());
    check_eq("ext",  ext_addr, exp_q.pop_front());
    check_eq("alu",  alu_result, exp_q.pop_front());
    check_eq("zero", 64'(zero), exp_q.pop_front());
    check_eq("tgt",  branch_target, exp_q.pop_front());
    check_eq("ctrl", 64'({uncondbranch, branch, mem_read, mem_to_reg, mem_write,
                          alu_src, reg_write, alu_op}), exp_q.pop_front());
  endtask

  function automatic logic [4:0] rand_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 8))
      0: return {11'h458, rand_reg(), 6'($urandom), rand_reg(), rand_reg()};
      1: return {11'h658, rand_reg(), 6'($urandom), rand_reg(), rand_reg()};
      2: return {11'h450, rand_reg(), 6'($urandom), rand_reg(), rand_reg()};
      3: return {11'h550, rand_reg(), 6'($urandom), rand_reg(), rand_reg()};
      4: return {11'h7C2, 9'($urandom), 2'b00, rand_reg(), rand_reg()};
      5: return {11'h7C0, 9'($urandom), 2'b00, rand_reg(), rand_reg()};
      6: return {8'hB4, 19'($urandom), rand_reg()};
      7: return {6'h05, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; instr = 32'd0; cur_pc = 64'd0; write_data = 64'd0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;

    apply(1'b1, 32'h8B020023, 64'h0, 64'd0);
    check_eq("rst_add_rd1", read_data1, 64'd0);
    check_eq("rst_add_rd2", read_data2, 64'd0);
    check_eq("rst_add_alu", alu_result, 64'd0);
    check_eq("rst_add_zero", 64'(zero), 64'd1);
    check_eq("rst_add_op", 64'({reg_write, alu_op}), 64'b110);

    apply(1'b1, 32'hF8408001, 64'h4, 64'd20);
    check_eq("ldur_ext", ext_addr, 64'd8);
    check_eq("ldur_alu", alu_result, 64'd8);
    check_eq("ldur_ctl", 64'({mem_read, mem_to_reg, alu_src}), 64'b111);
    apply(1'b1, 32'hF8408002, 64'h8, 64'd10);
    apply(1'b1, 32'h8B020023, 64'hC, 64'd30);
    check_eq("add_30", alu_result, 64'd30);
    apply(1'b1, 32'hCB030064, 64'h10, 64'd0);
    check_eq("sub_alu", alu_result, 64'd0);
    check_eq("sub_zero", 64'(zero), 64'd1);
    apply(1'b1, 32'hAA020025, 64'h14, 64'd0);
    check_eq("orr_alu", alu_result, 64'd30);
    apply(1'b1, 32'hB4FFFFC5, 64'h40, 64'd0);
    check_eq("cbz_ext", ext_addr, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("cbz_tgt", branch_target, 64'h38);
    check_eq("cbz_br_zero", 64'({branch, zero}), 64'b11);
    apply(1'b1, 32'h14000003, 64'h100, 64'd0);
    check_eq("b_tgt", branch_target, 64'h10C);
    check_eq("b_ctl", 64'({uncondbranch, reg_write}), 64'b10);

    apply(1'b1, 32'hF840801F, 64'h0, 64'd14);
    apply(1'b1, {11'h550, 5'd31, 6'd0, 5'd31, 5'd7}, 64'h0, 64'd0);
    check_eq("x31_rd1", read_data1, 64'd0);
    check_eq("x31_rd2", read_data2, 64'd0);

    apply(1'b1, {11'h7C2, 9'd0, 2'b00, 5'd0, 5'd6}, 64'h0, 64'd5);
    apply(1'b1, {11'h7C2, 9'd8, 2'b00, 5'd6, 5'd6}, 64'h0, 64'd14);
    check_eq("x6_same_cycle", read_data1, BYP ? 64'd14 : 64'd5);
    apply(1'b1, {11'h550, 5'd31, 6'd0, 5'd6, 5'd7}, 64'h0, 64'd0);
    check_eq("x6_after", read_data1, 64'd14);

    // Reset in mid-sequence: the write in that cycle is dropped and X1/X2 clear.
    apply(1'b0, 32'hF8408001, 64'h0, 64'd99);
    apply(1'b1, 32'h8B020023, 64'h0, 64'd0);
    check_eq("midrst_rd1", read_data1, 64'd0);
    check_eq("midrst_rd2", read_data2, 64'd0);

    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, rand_instr(),
            {$urandom, $urandom}, {$urandom, $urandom});
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
